liu_approx_seq_mult: RTL and testbench



---
 rtl/liu_approx_seq_mult.sv | 161 ++++++++++++++++
 tb/tb_liu_approx_seq_mult.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/liu_approx_seq_mult.sv
// liu_approx_seq_mult: iterative unsigned approximate multiplier.
//
// Each RUN cycle retires one multiplier bit pair (two partial products) into a
// 2*WIDTH accumulator. Product columns below APPROX_BITS use the Liu-style
// approximate cell; columns at and above it use exact addition. The number of
// approximation events per operation is counted in a saturating counter.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake (a_in = multiplicand, b_in = multiplier)
//   out_valid / out_ready result handshake
//   product               2*WIDTH approximate product
//   err_cnt               approximation events in the last operation (saturating)
//
// Optional build macro:
//   LIU_MULT_ZERO_SKIP_EN  finish early once all remaining multiplier bits are zero.

module liu_approx_seq_mult #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [ERR_W-1:0]     err_cnt
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned Pairs = WIDTH / 2;
  localparam int unsigned JW    = (Pairs > 1) ? $clog2(Pairs) : 1;
  localparam int unsigned CW    = $clog2(PW + 1);
  localparam int unsigned SW    = ((ERR_W > CW) ? ERR_W : CW) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [PW-1:0] lo_mask_f();
    logic [PW-1:0] m;
    for (int unsigned i = 0; i < PW; i++) begin
      m[i] = (i < APPROX_BITS);
    end
    return m;
  endfunction

  localparam logic [PW-1:0]    LoMask = lo_mask_f();
  localparam logic [ERR_W-1:0] ErrMax = {ERR_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [JW-1:0]    j_q, j_d;

  logic [JW:0]      sh;
  logic [1:0]       q_pair;
  logic [PW-1:0]    m_ext, p0, p1;
  logic [PW-1:0]    approx_sum, exact_sum, acc_step, err_bits;
  logic [CW-1:0]    err_pop;
  logic [SW-1:0]    err_sum;
  logic             run_done;

  // Partial products for the current pair (2j, 2j+1).
  always_comb begin
    sh     = {j_q, 1'b0};
    q_pair = 2'(q_q >> sh);
    m_ext  = {{WIDTH{1'b0}}, m_q};
    p0     = q_pair[0] ? (m_ext << sh) : '0;
    p1     = q_pair[1] ? ((m_ext << sh) << 1) : '0;
  end

  // Low columns: approximate cell, no carry leaves the region.
  // High columns: exact three-operand sum; low bits are masked to zero so no
  // carry enters from below.
  always_comb begin
    approx_sum = ((acc_q ^ p0) | p1) & LoMask;
    err_bits   = (acc_q ^ p0) & p1 & LoMask;
    exact_sum  = (acc_q & ~LoMask) + (p0 & ~LoMask) + (p1 & ~LoMask);
    acc_step   = approx_sum | exact_sum;
    err_pop    = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      err_pop = err_pop + CW'(err_bits[i]);
    end
    err_sum = SW'(err_q) + SW'(err_pop);
  end

`ifdef LIU_MULT_ZERO_SKIP_EN
  // Stop once nothing above the current pair remains; processing a zero pair
  // leaves acc untouched, so finishing this cycle is result-identical.
  assign run_done = (j_q == JW'(Pairs - 1)) || (((q_q >> sh) >> 2) == '0);
`else
  assign run_done = (j_q == JW'(Pairs - 1));
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    err_d   = err_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = a_in;
          q_d     = b_in;
          acc_d   = '0;
          err_d   = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_step;
        err_d = (err_sum > SW'(ErrMax)) ? ErrMax : err_sum[ERR_W-1:0];
        if (run_done) begin
          j_d     = '0;
          state_d = DONE;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      err_q   <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      j_q     <= j_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = acc_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_liu_approx_seq_mult.sv
// Directed bench for liu_approx_seq_mult. Three instances share all inputs:
//   u_exact : APPROX_BITS=0  (exact reference behaviour)
//   u_apx4  : APPROX_BITS=4
//   u_sat   : APPROX_BITS=16, ERR_W=2 (fully approximate, tiny counter)
module tb_liu_approx_seq_mult;

`ifdef LIU_MULT_ZERO_SKIP_EN
  localparam int LatQ03 = 1;
  localparam int LatQ00 = 1;
  localparam int LatQ11 = 2;
`else
  localparam int LatQ03 = 4;
  localparam int LatQ00 = 4;
  localparam int LatQ11 = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;

  logic        rdy0, vld0, rdy1, vld1, rdy2, vld2;
  logic [15:0] prod0, prod1, prod2;
  logic [7:0]  err0, err1;
  logic [1:0]  err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  liu_approx_seq_mult #(.WIDTH(8), .APPROX_BITS(0), .ERR_W(8)) u_exact (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .a_in(a_in), .b_in(b_in), .out_valid(vld0), .out_ready(out_ready),
    .product(prod0), .err_cnt(err0)
  );

  liu_approx_seq_mult #(.WIDTH(8), .APPROX_BITS(4), .ERR_W(8)) u_apx4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .a_in(a_in), .b_in(b_in), .out_valid(vld1), .out_ready(out_ready),
    .product(prod1), .err_cnt(err1)
  );

  liu_approx_seq_mult #(.WIDTH(8), .APPROX_BITS(16), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .a_in(a_in), .b_in(b_in), .out_valid(vld2), .out_ready(out_ready),
    .product(prod2), .err_cnt(err2)
  );

  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid; gives up at 20.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!vld0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", rdy0); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", vld0); end
    checks++; if (prod0 !== 16'd0) begin errors++; $display("FAIL reset_product got %0d want 0", prod0); end
    checks++; if (err1 !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err1); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exact();
    int lat;
    start_op(8'd200, 8'd150);
    wait_done(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL exact_latency got %0d want 4", lat); end
    checks++; if (prod0 !== 16'd30000) begin errors++; $display("FAIL exact_product got %0d want 30000", prod0); end
    checks++; if (err0 !== 8'd0) begin errors++; $display("FAIL exact_err got %0d want 0", err0); end
    release_op();
  endtask

  task automatic test_approx();
    int lat;
    start_op(8'h0F, 8'h03);
    wait_done(lat);
    checks++; if (lat !== LatQ03) begin errors++; $display("FAIL approx_latency got %0d want %0d", lat, LatQ03); end
    checks++; if (prod1 !== 16'd31) begin errors++; $display("FAIL approx_product got %0d want 31", prod1); end
    checks++; if (err1 !== 8'd3) begin errors++; $display("FAIL approx_err got %0d want 3", err1); end
    checks++; if (prod0 !== 16'd45) begin errors++; $display("FAIL approx_exact_ref got %0d want 45", prod0); end
    release_op();
  endtask

  task automatic test_saturation();
    int lat;
    start_op(8'hFF, 8'hFF);
    wait_done(lat);
    checks++; if (prod0 !== 16'd65025) begin errors++; $display("FAIL sat_exact_product got %0d want 65025", prod0); end
    checks++; if (prod1 !== 16'hFDDB) begin errors++; $display("FAIL sat_apx4_product got %h want fddb", prod1); end
    checks++; if (err1 !== 8'd3) begin errors++; $display("FAIL sat_apx4_err got %0d want 3", err1); end
    checks++; if (prod2 !== 16'h7FAB) begin errors++; $display("FAIL sat_full_product got %h want 7fab", prod2); end
    checks++; if (err2 !== 2'd3) begin errors++; $display("FAIL sat_err_cnt got %0d want 3", err2); end
    release_op();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(8'd13, 8'd11);
    wait_done(lat);
    checks++; if (lat !== LatQ11) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, LatQ11); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (vld0 !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", vld0); end
      checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", rdy0); end
      checks++; if (prod0 !== 16'd143) begin errors++; $display("FAIL bp_product got %0d want 143", prod0); end
      @(posedge clk); #1;
    end
    release_op();
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", rdy0); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got %b want 0", vld0); end
    checks++; if (prod0 !== 16'd143) begin errors++; $display("FAIL bp_idle_hold got %0d want 143", prod0); end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start_op(8'd200, 8'd150);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", vld0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", rdy0); end
    checks++; if (prod0 !== 16'd0) begin errors++; $display("FAIL midrst_product got %0d want 0", prod0); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(8'd13, 8'd11);
    wait_done(lat);
    checks++; if (lat !== LatQ11) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat, LatQ11); end
    checks++; if (prod0 !== 16'd143) begin errors++; $display("FAIL midrst_product_after got %0d want 143", prod0); end
    release_op();
  endtask

  task automatic test_busy_ignored();
    int lat;
    start_op(8'd200, 8'd150);
    a_in = 8'd1;
    b_in = 8'd1;
    in_valid = 1'b1;
    wait_done(lat);
    in_valid = 1'b0;
    checks++; if (prod0 !== 16'd30000) begin errors++; $display("FAIL busy_product got %0d want 30000", prod0); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL busy_latency got %0d want 4", lat); end
    release_op();
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL busy_idle_ready got %b want 1", rdy0); end
  endtask

  task automatic test_zero_skip();
    int lat;
    start_op(8'hAB, 8'h00);
    wait_done(lat);
    checks++; if (lat !== LatQ00) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, LatQ00); end
    checks++; if (prod0 !== 16'd0) begin errors++; $display("FAIL zero_product got %0d want 0", prod0); end
    checks++; if (err1 !== 8'd0) begin errors++; $display("FAIL zero_err got %0d want 0", err1); end
    release_op();
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_saturation();
    test_backpressure();
    test_reset_mid_run();
    test_busy_ignored();
    test_zero_skip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
